// File: rtl/shift_right_unit_pkg.sv
// -----------------------------------------------------------------------------
// shift_right_unit_pkg
// Shared definitions for the multi-cycle right shifter: FSM state encoding and
// default data / shift-amount widths.
// -----------------------------------------------------------------------------
package shift_right_unit_pkg;

    localparam int SRU_WIDTH   = 8;
    localparam int SRU_SHAMT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_right_unit.sv
// -----------------------------------------------------------------------------
// shift_right_unit
// Iterative right shifter: shifts B right by A positions, one bit per clock,
// with zero fill (logical) or sign fill (arithmetic).
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset, aborts any operation
//   start        in   begin a shift (only looked at while idle)
//   arith        in   0 = logical, 1 = arithmetic fill
//   A            in   shift amount, 0..WIDTH-1
//   B            in   operand
//   busy         out  high while an operation is in flight (SHIFT or DONE)
//   done         out  one-cycle pulse, Shift_Result valid in that cycle
//   Shift_Result out  registered result, held while idle
// -----------------------------------------------------------------------------
module shift_right_unit
    import shift_right_unit_pkg::*;
#(
    parameter int WIDTH   = SRU_WIDTH,
    parameter int SHAMT_W = SRU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Shift_Result
);

    if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt_w
        $error("shift_right_unit: SHAMT_W must equal clog2(WIDTH)");
    end

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q,   cnt_d;
    logic               mode_q,  mode_d;
    logic [WIDTH-1:0]   data_q,  data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = B;
                    cnt_d   = A;
                    mode_d  = arith;
                    // A zero-length shift skips straight to the result pulse.
                    state_d = (A == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Sign fill reuses the current MSB; logical fill forces zero.
                data_d = {mode_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    // Status decoded from registered state only: no input-to-output path.
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign Shift_Result = data_q;

endmodule
